load_store_unit: RTL and testbench

//  Data-memory side of the RV32I datapath. Takes the effective address computed by the ALU,

---
 rtl/load_store_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory side of the RV32I datapath. Accepts one load/store from the
//   execute stage, runs it on a req/gnt/rvalid memory bus, and returns the
//   loaded value aligned and sign/zero-extended. Byte-lane steering and
//   load/store decoding live here.
//
//   Build option: MISALIGN_TRAP_EN
//     defined   : misaligned half/word accesses skip the bus and respond with
//                 rsp_err=1, misalign=1.
//     undefined : misalign is tied 0; half ignores addr[0], word ignores
//                 addr[1:0], and the access proceeds normally.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/req_ready      core request handshake (ready only in IDLE)
//     req_we, req_funct3       store/load select, RV32I size/sign encoding
//     req_addr, req_wdata      byte effective address, store data
//     rsp_valid                1-cycle completion pulse
//     rsp_rdata, rsp_err       extended load data, error flag
//     misalign                 misaligned-access flag (trap build only)
//     busy                     core stall while a transaction is open
//     mem_req/mem_gnt          bus request, held until granted
//     mem_we, mem_addr         write enable, word-aligned address
//     mem_be, mem_wdata        byte enables, lane-replicated store data
//     mem_rvalid, mem_rdata    read data / write ack

// One byte lane of the store path: enable and the data byte it carries.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,   // 00 byte, 01 half, 10 word
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] L = 2'(LANE);

  logic [1:0] sel;

  always_comb begin
    be  = 1'b1;
    sel = L;
    case (size)
      2'b00: begin
        be  = (off == L);
        sel = 2'b00;
      end
      2'b01: begin
        // Half only looks at off[1]; off[0] is either trapped or ignored.
        be  = (off[1] == L[1]);
        sel = {1'b0, L[0]};
      end
      default: begin
        be  = 1'b1;
        sel = L;
      end
    endcase
    wbyte = wd[{sel, 3'b000} +: 8];
  end
endmodule

module load_store_unit #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        misalign,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int NUM_LANES = 4;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, RESP} state_t;

  state_t state, state_nxt;

  logic                           we_q;
  logic [2:0]                     f3_q;
  logic [1:0]                     off_q;
  logic [29:0]                    waddr_q;
  logic [NUM_LANES-1:0]           be_q;
  logic [NUM_LANES-1:0][7:0]      wdata_q;
  logic [31:0]                    rdata_q;
  logic                           err_q;
  logic [15:0]                    to_cnt;

  logic [NUM_LANES-1:0]           lane_be;
  logic [NUM_LANES-1:0][7:0]      lane_wdata;

  logic f3_ok, mis_det, accept, reject;
  logic timeout_hit, rsp_take, to_fire;
  logic [31:0] load_val;

  // ---------------------------------------------------------------- decode
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_lane #(.LANE(i)) u_lane (
      .size  (req_funct3[1:0]),
      .off   (req_addr[1:0]),
      .wd    (req_wdata),
      .be    (lane_be[i]),
      .wbyte (lane_wdata[i])
    );
  end

  always_comb begin
    if (req_we) f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
    else        f3_ok = (req_funct3 != 3'b011) && (req_funct3[2:1] != 2'b11);
  end

`ifdef MISALIGN_TRAP_EN
  assign mis_det = f3_ok &&
                   (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`else
  assign mis_det = 1'b0;
`endif

  assign accept = (state == IDLE) && req_valid;
  assign reject = !f3_ok || mis_det;

  // Bus progress wins over the timeout when both land on the same cycle.
  assign timeout_hit = (to_cnt == TO_LAST);
  assign rsp_take    = ((state == WAIT_GNT) && mem_gnt && mem_rvalid) ||
                       ((state == WAIT_RSP) && mem_rvalid);
  assign to_fire     = timeout_hit && !rsp_take &&
                       (((state == WAIT_GNT) && !mem_gnt) || (state == WAIT_RSP));

  // ----------------------------------------------------------- load extract
  always_comb begin
    logic [1:0]  shamt;
    logic [31:0] s;
    case (f3_q[1:0])
      2'b00:   shamt = off_q;
      2'b01:   shamt = {off_q[1], 1'b0};
      default: shamt = 2'b00;
    endcase
    s = mem_rdata >> {shamt, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{s[7]}},  s[7:0]};
      3'b001:  load_val = {{16{s[15]}}, s[15:0]};
      3'b100:  load_val = {24'h0, s[7:0]};
      3'b101:  load_val = {16'h0, s[15:0]};
      default: load_val = s;
    endcase
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_valid) state_nxt = reject ? RESP : WAIT_GNT;
      WAIT_GNT: begin
        if (mem_gnt && mem_rvalid) state_nxt = RESP;
        else if (mem_gnt)          state_nxt = WAIT_RSP;
        else if (timeout_hit)      state_nxt = RESP;
      end
      WAIT_RSP: if (mem_rvalid || timeout_hit) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && err_q;
    rsp_rdata = (state == RESP) ? rdata_q : 32'h0;
    mem_req   = (state == WAIT_GNT);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_req ? {waddr_q, 2'b00} : 32'h0;
    mem_be    = (mem_req && we_q) ? be_q : 4'h0;
    mem_wdata = (mem_req && we_q) ? wdata_q : 32'h0;
  end

  // ------------------------------------------------------- transaction data
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      waddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        waddr_q <= req_addr[31:2];
        be_q    <= lane_be;
        wdata_q <= lane_wdata;
        rdata_q <= '0;
        err_q   <= reject;
        to_cnt  <= '0;
      end else if ((state == WAIT_GNT) || (state == WAIT_RSP)) begin
        to_cnt <= to_cnt + 16'd1;
        if (rsp_take && !we_q) rdata_q <= load_val;
        if (to_fire) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (rst)         mis_q <= 1'b0;
    else if (accept) mis_q <= mis_det;
  end
  assign misalign = (state == RESP) && mis_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, misalign, busy;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .misalign(misalign), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One transaction. Entered at a negedge with the DUT idle; returns at the
  // negedge after the response with the bus inputs quiet.
  // g/r: wait-cycle index (1 = first cycle after accept) at which gnt/rvalid
  // are driven; 0 = never.
  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int g, input int r,
                        input logic [31:0] rd);
    bit          bad, mis;
    int          size, off, resp, greq_last, v, o;
    int          b[4];
    logic [31:0] exp_be, exp_wd, exp_rd;
    bit          exp_err;

    bad  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    size = int'(f3) % 4;
    off  = int'(addr) & 3;
    mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (!bad && ((size == 1 && (off % 2) == 1) || (size == 2 && off != 0))) mis = 1'b1;
`endif
    exp_be = 0;
    exp_wd = 0;
    if (we) begin
      case (size)
        0:       begin exp_be = 32'(1 << off);       exp_wd = 32'(wd[7:0])  * 32'h0101_0101; end
        1:       begin exp_be = 32'(3 << (off & 2)); exp_wd = 32'(wd[15:0]) * 32'h0001_0001; end
        default: begin exp_be = 32'hF;               exp_wd = wd; end
      endcase
    end
    for (int i = 0; i < 4; i++) b[i] = int'((rd >> (8 * i)) & 32'hFF);
    case (size)
      0: begin v = b[off]; if (f3 == 3'd0 && v >= 128) v -= 256; exp_rd = 32'(v); end
      1: begin
        o = off & 2;
        v = b[o] + 256 * b[o + 1];
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
        exp_rd = 32'(v);
      end
      default: exp_rd = rd;
    endcase
    if (we) exp_rd = 0;

    if (bad || mis) begin
      resp = 1; greq_last = 0; exp_err = 1'b1; exp_rd = 0;
    end else if (g != 0 && r != 0) begin
      resp = r + 1; greq_last = g; exp_err = 1'b0;
    end else begin
      resp = TO + 1; greq_last = (g != 0) ? g : TO; exp_err = 1'b1; exp_rd = 0;
    end

    // cycle 0: present request; idle-state bus noise must be ignored
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    mem_gnt    = 1'($urandom);
    mem_rvalid = 1'($urandom);
    mem_rdata  = $urandom;

    for (int c = 1; c <= resp + 1; c++) begin
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'(c == resp));
      chk("busy",      32'(busy),      32'(c <= resp));
      chk("req_ready", 32'(req_ready), 32'(c > resp));
      chk("mem_req",   32'(mem_req),   32'(c <= greq_last));
      if (c <= greq_last) begin
        chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("mem_we",   32'(mem_we), 32'(we));
        chk("mem_be",   32'(mem_be), exp_be);
        if (we) chk("mem_wdata", mem_wdata, exp_wd);
      end
      if (c == resp) begin
        chk("rsp_err",   32'(rsp_err),  32'(exp_err));
        chk("rsp_rdata", rsp_rdata,     exp_rd);
        chk("misalign",  32'(misalign), 32'(mis));
      end
      // drive this cycle's inputs; noise only where the DUT must ignore it
      if (c <= resp) begin
        req_valid  = 1'($urandom);
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
      end else req_valid = 1'b0;
      mem_gnt    = (c == g) ||
                   ((bad || mis || c > ((g != 0) ? g : resp - 1)) && 1'($urandom));
      mem_rvalid = (c == r) ||
                   ((bad || mis || c >= resp || (g == 0) || (c < g)) && 1'($urandom));
      if (!(bad || mis) && c < resp && g != 0 && c == g && r != g) mem_rvalid = 1'b0;
      mem_rdata  = (c == r) ? rd : $urandom;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst busy",      32'(busy),      32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_err",   32'(rsp_err),   32'd0);
    chk("rst misalign",  32'(misalign),  32'd0);
    chk("rst mem_req",   32'(mem_req),   32'd0);
    chk("rst mem_we",    32'(mem_we),    32'd0);
    chk("rst mem_be",    32'(mem_be),    32'd0);
    chk("rst mem_addr",  mem_addr,       32'd0);
    chk("rst mem_wdata", mem_wdata,      32'd0);
    chk("rst rsp_rdata", rsp_rdata,      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    do_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0,         1, 2, 32'h80FF_1234); // LB
    do_txn(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 1, 2, 32'h0);         // SH
    do_txn(1'b0, 3'b010, 32'h0000_0400, 32'h0,         1, 2, 32'h1234_5678); // LW min latency
    do_txn(1'b0, 3'b010, 32'h0000_0404, 32'h0,         1, 1, 32'hCAFE_F00D); // b2b, gnt+rvalid same cycle
    do_txn(1'b0, 3'b101, 32'h0000_0012, 32'h0,         6, 7, 32'h8001_0000); // LHU, gnt 5 cycles late
    do_txn(1'b0, 3'b010, 32'h0000_0020, 32'h0,         0, 0, 32'h0);         // timeout in WAIT_GNT
    do_txn(1'b1, 3'b010, 32'h0000_0024, 32'h1111_2222, 2, 0, 32'h0);         // timeout in WAIT_RSP
    do_txn(1'b0, 3'b011, 32'h0000_0030, 32'h0,         1, 2, 32'h0);         // bad load funct3
    do_txn(1'b1, 3'b100, 32'h0000_0030, 32'h5,         1, 2, 32'h0);         // bad store funct3
    do_txn(1'b0, 3'b001, 32'h0000_0033, 32'h0,         1, 2, 32'h0000_FF7F); // LH off=3

    // reset in WAIT_RSP
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0;
    chk("pre-rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst busy",      32'(busy),      32'd0);
    chk("mid-rst mem_req",   32'(mem_req),   32'd0);
    chk("mid-rst req_ready", 32'(req_ready), 32'd1);
    chk("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post-rst req_ready", 32'(req_ready), 32'd1);
    mem_rvalid = 1'b0;
    do_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 1, 1, 32'hA5A5_5A5A);           // LW misaligned

    // randomized traffic
    for (int t = 0; t < 250; t++) begin
      int g, r;
      g = 1 + int'($urandom_range(0, 3));
      r = g + int'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) g = 0;
        r = 0;
      end
      do_txn(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, g, r, $urandom);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
